// File: rtl/video_scan_pkg.sv
// Shared raster timing, memory-map and interrupt constants for the video scanner.
// VIDEO_SCAN_FLIP_EN selects the 180-degree rotated (cocktail) address mapping.
package video_scan_pkg;
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Native 256x224 picture shown 2x scaled inside the 640x480 raster
  localparam logic [9:0] X_OFS    = 10'd64;
  localparam logic [9:0] Y_OFS    = 10'd16;
  localparam logic [9:0] NATIVE_W = 10'd256;
  localparam logic [9:0] NATIVE_H = 10'd224;
  localparam logic [9:0] WIN_W    = NATIVE_W << 1;
  localparam logic [9:0] WIN_H    = NATIVE_H << 1;
  localparam logic [9:0] X_END    = X_OFS + WIN_W;
  localparam logic [9:0] Y_END    = Y_OFS + WIN_H;

  localparam int         BYTES_PER_LINE = 32;
  localparam logic [9:0] FETCH_LEAD     = 10'd4;
  localparam logic [9:0] FETCH_FIRST    = X_OFS - FETCH_LEAD;
  localparam logic [9:0] FETCH_LAST     = FETCH_FIRST + 10'(16 * (BYTES_PER_LINE - 1));
  localparam logic [13:0] VRAM_BASE     = 14'h2400;

  localparam logic [9:0] IRQ_MID_LINE = 10'd96;
  localparam logic [9:0] IRQ_END_LINE = 10'd224;
  localparam logic [9:0] IRQ_MID_V    = Y_OFS + (IRQ_MID_LINE << 1);
  localparam logic [9:0] IRQ_END_V    = Y_OFS + (IRQ_END_LINE << 1);

  function automatic logic [13:0] vram_addr(input logic [7:0] y, input logic [4:0] k);
`ifdef VIDEO_SCAN_FLIP_EN
    return VRAM_BASE + 14'h1BFF - {1'b0, y, k};
`else
    return VRAM_BASE + {1'b0, y, k};
`endif
  endfunction
endpackage

// File: rtl/video_timing.sv
// Free-running 640x480@60 raster counters with raw (unregistered) sync,
// display-enable and picture-window flags derived from the current position.
module video_timing
  import video_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       win_cols,
  output logic       win_rows
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_TOTAL - 10'd1) begin
      h <= '0;
      v <= (v == V_TOTAL - 10'd1) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  always_comb begin
    hsync    = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    vsync    = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    de       = (h < H_ACTIVE) && (v < V_ACTIVE);
    win_cols = (h >= X_OFS) && (h < X_END);
    win_rows = (v >= Y_OFS) && (v < Y_END);
  end
endmodule

// File: rtl/video_scan.sv
// VGA scan-out of the 1bpp video RAM: byte fetch, hold/shift serialiser and
// per-frame CPU interrupts. Define VIDEO_SCAN_FLIP_EN for the rotated picture.
module video_scan
  import video_scan_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [13:0] o_addr2,
  output logic        o_read2,
  input  logic [7:0]  i_data2,
  input  logic        i_ready2,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_pixel,
  output logic        o_irq_mid,
  output logic        o_irq_end
);
  logic [9:0]  h, v, h_ahead;
  logic        hsync, vsync, de, win_cols, win_rows;
  logic        fetch_now, load, pix_odd, pix_bit;
  logic [13:0] fetch_addr;
  logic [7:0]  hold, shift, cur, shift_next;

  video_timing u_timing (
    .clk      (i_clk),
    .rst      (i_rst),
    .h        (h),
    .v        (v),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .win_cols (win_cols),
    .win_rows (win_rows)
  );

  always_comb begin
    // Strobe is registered, so decide one clock early to land on the fetch slot
    h_ahead    = h + 10'd1;
    fetch_now  = win_rows && (h_ahead >= FETCH_FIRST) && (h_ahead <= FETCH_LAST)
                 && (4'(h_ahead - FETCH_FIRST) == 4'd0);
    fetch_addr = vram_addr(8'((v - Y_OFS) >> 1), 5'((h_ahead - FETCH_FIRST) >> 4));
    load       = win_cols && (4'(h - X_OFS) == 4'd0);
    pix_odd    = 1'(h - X_OFS);
    // Bypass the hold byte on the load slot so its first pixel is not delayed
    cur        = load ? hold : shift;
`ifdef VIDEO_SCAN_FLIP_EN
    pix_bit    = cur[7];
    shift_next = pix_odd ? (cur << 1) : cur;
`else
    pix_bit    = cur[0];
    shift_next = pix_odd ? (cur >> 1) : cur;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hsync   <= 1'b1;
      o_vsync   <= 1'b1;
      o_de      <= 1'b0;
      o_pixel   <= 1'b0;
      o_irq_mid <= 1'b0;
      o_irq_end <= 1'b0;
      o_read2   <= 1'b0;
      o_addr2   <= VRAM_BASE;
      hold      <= '0;
      shift     <= '0;
    end else begin
      o_hsync   <= hsync;
      o_vsync   <= vsync;
      o_de      <= de;
      o_pixel   <= win_cols && win_rows && pix_bit;
      o_irq_mid <= (h == 10'd0) && (v == IRQ_MID_V);
      o_irq_end <= (h == 10'd0) && (v == IRQ_END_V);
      o_read2   <= fetch_now;
      if (fetch_now) o_addr2 <= fetch_addr;
      // A missing response simply leaves the previous byte in place
      if (i_ready2) hold <= i_data2;
      shift     <= shift_next;
    end
  end
endmodule
